pixel_row_reader: RTL and testbench



---
 rtl/pixel_row_reader.sv | 164 ++++++++++++++++
 tb/tb_pixel_row_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_reader.sv
// pixel_row_reader
//
// Readout sequencer for the pixel array row bus. On an accepted start it walks
// the rows in order: it drives a one-hot row select on `read` for SETTLE_CYCLES
// cycles, captures the settled row bus into a local buffer, then streams that
// row's pixels one per transfer over a valid/ready handshake. A one-cycle `done`
// pulse follows the final pixel of the frame.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a frame; only honoured while idle, never queued
//   test_mode  (READER_TEST_PATTERN_EN only) latched at start; selects the
//              synthetic ramp pattern instead of the pixel array
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse after the last pixel transfer
//   read       one-hot row select to the pixel array
//   row_data   packed row bus from the pixel array, column c at [c*8 +: 8]
//   pix_data   current pixel value
//   pix_row    row index of pix_data
//   pix_col    column index of pix_data
//   pix_last   marks the final pixel of the frame
//   pix_valid  pix_* outputs are valid
//   pix_ready  consumer accepts the pixel this cycle
//
// Build option: define READER_TEST_PATTERN_EN to add the `test_mode` input. In
// test mode `read` stays low, row_data is ignored, and each captured pixel is
// (row * PIXEL_ARRAY_WIDTH + col) mod 256; sequencing is unchanged.

module pixel_row_reader #(
  parameter int unsigned PIXEL_ARRAY_WIDTH  = 2,
  parameter int unsigned PIXEL_ARRAY_HEIGHT = 2,
  parameter int unsigned SETTLE_CYCLES      = 2,
  localparam int unsigned RowW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
  localparam int unsigned ColW = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
`ifdef READER_TEST_PATTERN_EN
  input  logic                           test_mode,
`endif
  output logic                           busy,
  output logic                           done,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]  read,
  input  logic [PIXEL_ARRAY_WIDTH*8-1:0] row_data,
  output logic [7:0]                     pix_data,
  output logic [RowW-1:0]                pix_row,
  output logic [ColW-1:0]                pix_col,
  output logic                           pix_last,
  output logic                           pix_valid,
  input  logic                           pix_ready
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StSelect, StStream, StDone} state_t;

  state_t          state;
  logic [RowW-1:0] row;
  logic [ColW-1:0] col;
  logic [CntW-1:0] cnt;
  logic            tm;        // test-pattern mode latched for the current frame
  logic            start_tm;  // mode value to latch when start is accepted
  logic [7:0]      buffer [PIXEL_ARRAY_WIDTH];
  logic [7:0]      cap    [PIXEL_ARRAY_WIDTH];

`ifdef READER_TEST_PATTERN_EN
  assign start_tm = test_mode;
`else
  assign start_tm = 1'b0;
`endif

  // Value each column would take if the row were captured on this edge.
  always_comb begin
    for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin
      cap[c] = tm ? 8'(int'(row) * PIXEL_ARRAY_WIDTH + c) : row_data[c*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      row       <= '0;
      col       <= '0;
      cnt       <= '0;
      tm        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      read      <= '0;
      pix_data  <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_last  <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state <= StSelect;
            row   <= '0;
            cnt   <= '0;
            tm    <= start_tm;
            busy  <= 1'b1;
            read  <= start_tm ? '0 : PIXEL_ARRAY_HEIGHT'(1);
          end
        end

        StSelect: begin
          if (cnt == CntW'(SETTLE_CYCLES - 1)) begin
            // Row bus has settled: capture the whole row and present column 0.
            for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin
              buffer[c] <= cap[c];
            end
            state     <= StStream;
            read      <= '0;
            col       <= '0;
            pix_valid <= 1'b1;
            pix_data  <= cap[0];
            pix_row   <= row;
            pix_col   <= '0;
            pix_last  <= (row == RowW'(PIXEL_ARRAY_HEIGHT - 1)) && (PIXEL_ARRAY_WIDTH == 1);
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        StStream: begin
          if (pix_ready) begin
            if (col == ColW'(PIXEL_ARRAY_WIDTH - 1)) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              if (row == RowW'(PIXEL_ARRAY_HEIGHT - 1)) begin
                state <= StDone;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                // Next row select goes out on the same edge as the last transfer.
                state <= StSelect;
                row   <= row + RowW'(1);
                cnt   <= '0;
                read  <= tm ? '0 : PIXEL_ARRAY_HEIGHT'(1) << (row + RowW'(1));
              end
            end else begin
              col      <= col + ColW'(1);
              pix_col  <= col + ColW'(1);
              pix_data <= buffer[col + ColW'(1)];
              pix_last <= (row == RowW'(PIXEL_ARRAY_HEIGHT - 1)) &&
                          (col + ColW'(1) == ColW'(PIXEL_ARRAY_WIDTH - 1));
            end
          end
        end

        StDone: begin
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_row_reader.sv
// Self-checking bench for pixel_row_reader: reset/idle checks, a cycle-exact
// vector table for the reference frame, then frames checked against a
// raster-order pixel model with a behavioural pixel array driving row_data.

module tb_pixel_row_reader;

  localparam int W  = 2;
  localparam int H  = 2;
  localparam int S  = 2;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic           clk = 1'b0;
  logic           reset, start, pix_ready, test_mode;
  logic           busy, done, pix_valid, pix_last;
  logic [H-1:0]   read;
  logic [W*8-1:0] row_data = '0;
  logic [7:0]     pix_data;
  logic [RW-1:0]  pix_row;
  logic [CW-1:0]  pix_col;

  int   checks = 0;
  int   errors = 0;
  bit   tm = 1'b0;
  logic [7:0] img [H][W];

  typedef struct {
    bit         start;
    bit         ready;
    logic [H-1:0] read;
    bit         busy;
    bit         valid;
    bit         last;
    bit         done;
    logic [7:0] data;
    int         row;
    int         col;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         row;
    int         col;
    bit         last;
  } pix_t;

  vec_t tv [11];

  always #5 clk = ~clk;

  pixel_row_reader #(
    .PIXEL_ARRAY_WIDTH (W),
    .PIXEL_ARRAY_HEIGHT(H),
    .SETTLE_CYCLES     (S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef READER_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .busy     (busy),
    .done     (done),
    .read     (read),
    .row_data (row_data),
    .pix_data (pix_data),
    .pix_row  (pix_row),
    .pix_col  (pix_col),
    .pix_last (pix_last),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  // Pixel array: the selected row only appears on the bus once the select has
  // been held S-1 cycles; otherwise the bus carries fresh junk every cycle.
  logic [H-1:0] prev_read = '0;
  int           age = 0;
  always @(posedge clk) begin
    #1;
    if (read !== prev_read) age = 0;
    else age++;
    prev_read = read;
    for (int c = 0; c < W; c++) row_data[c*8 +: 8] = 8'($urandom);
    for (int r = 0; r < H; r++) begin
      if (read === (H'(1) << r) && age >= S - 1) begin
        for (int c = 0; c < W; c++) row_data[c*8 +: 8] = img[r][c];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rand_image();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
  endtask

  // One frame from an idle DUT. stall_idx >= 0 holds pix_ready low for three
  // cycles on that pixel (raster index); otherwise ready is random.
  task automatic run_frame(input int ready_pct, input int stall_idx, input bit noise);
    pix_t       q[$];
    pix_t       e;
    int         n, stalls, read_cycles, sent, hold, first_v;
    bit         prev_stall, finished;
    logic [7:0] pd;
    logic [RW-1:0] pr;
    logic [CW-1:0] pc;
    logic       pl;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        q.push_back('{tm ? 8'(r * W + c) : img[r][c], r, c, (r == H - 1 && c == W - 1)});
    n = 0; stalls = 0; read_cycles = 0; sent = 0; hold = 3; first_v = -1;
    prev_stall = 0; finished = 0; pd = '0; pr = '0; pc = '0; pl = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!finished) begin
      if (done) begin
        chk("frame length", n, H * (S + W) + stalls);
        chk("pixels left at done", q.size(), 0);
        chk("busy at done", busy, 0);
        chk("read cycles", read_cycles, tm ? 0 : H * S);
        finished = 1;
      end else if (n > 2000) begin
        checks++; errors++;
        $display("FAIL frame timeout: no done after %0d cycles, required within %0d", n, 2000);
        finished = 1;
      end else begin
        chk("busy in frame", busy, 1);
        if (read !== '0) begin
          read_cycles++;
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL read after frame: got 0x%0h, required 0x0", read);
          end else chk("read row select", read, H'(1) << q[0].row);
          chk("valid while read", pix_valid, 0);
        end
        if (prev_stall) begin
          chk("stall valid", pix_valid, 1);
          chk("stall data", pix_data, pd);
          chk("stall row", pix_row, pr);
          chk("stall col", pix_col, pc);
          chk("stall last", pix_last, pl);
        end
        if (pix_valid) begin
          if (first_v < 0) begin
            first_v = n;
            chk("first valid latency", n, S);
          end
          if (stall_idx >= 0) pix_ready = !(sent == stall_idx && hold > 0);
          else pix_ready = ($urandom_range(99) < ready_pct);
          if (pix_ready) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL extra pixel: got 0x%0h, required none", pix_data);
            end else begin
              e = q.pop_front();
              chk("pix_data", pix_data, e.data);
              chk("pix_row", pix_row, e.row);
              chk("pix_col", pix_col, e.col);
              chk("pix_last", pix_last, e.last);
              sent++;
            end
          end else begin
            stalls++;
            if (stall_idx >= 0) hold--;
          end
        end else begin
          chk("last without valid", pix_last, 0);
          pix_ready = 1'($urandom_range(1));
        end
        prev_stall = pix_valid && !pix_ready;
        pd = pix_data; pr = pix_row; pc = pix_col; pl = pix_last;
        start = noise && ($urandom_range(3) == 0);
        step();
        n++;
      end
    end
    // Done cycle: a start here must be ignored, and done must not repeat.
    start = noise;
    step();
    start = 1'b0;
    chk("done single pulse", done, 0);
    chk("start in done ignored", busy, 0);
  endtask

  initial begin
    int  n;
    bit  seen;
    reset = 1'b1; start = 1'b0; pix_ready = 1'b0; test_mode = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = '0;

    repeat (3) step();
    chk("reset read", read, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset valid", pix_valid, 0);
    chk("reset last", pix_last, 0);
    chk("reset data", pix_data, 0);
    chk("reset row", pix_row, 0);
    chk("reset col", pix_col, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle read", read, 0);
      chk("idle valid", pix_valid, 0);
      chk("idle busy", busy, 0);
      chk("idle done", done, 0);
    end

    // Reference frame, cycle by cycle: start, busy start pulses, done-cycle start.
    img[0][0] = 8'h11; img[0][1] = 8'h22; img[1][0] = 8'h33; img[1][1] = 8'h44;
    tv[0]  = '{1, 1, 2'b01, 1, 0, 0, 0, 8'h00, 0, 0};
    tv[1]  = '{0, 1, 2'b01, 1, 0, 0, 0, 8'h00, 0, 0};
    tv[2]  = '{0, 1, 2'b00, 1, 1, 0, 0, 8'h11, 0, 0};
    tv[3]  = '{0, 1, 2'b00, 1, 1, 0, 0, 8'h22, 0, 1};
    tv[4]  = '{1, 1, 2'b10, 1, 0, 0, 0, 8'h00, 0, 0};
    tv[5]  = '{0, 1, 2'b10, 1, 0, 0, 0, 8'h00, 0, 0};
    tv[6]  = '{1, 1, 2'b00, 1, 1, 0, 0, 8'h33, 1, 0};
    tv[7]  = '{0, 1, 2'b00, 1, 1, 1, 0, 8'h44, 1, 1};
    tv[8]  = '{0, 1, 2'b00, 0, 0, 0, 1, 8'h00, 0, 0};
    tv[9]  = '{1, 1, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0};
    tv[10] = '{0, 1, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0};
    for (int k = 0; k < 11; k++) begin
      start = tv[k].start;
      pix_ready = tv[k].ready;
      step();
      chk($sformatf("vec%0d read", k), read, tv[k].read);
      chk($sformatf("vec%0d busy", k), busy, tv[k].busy);
      chk($sformatf("vec%0d valid", k), pix_valid, tv[k].valid);
      chk($sformatf("vec%0d last", k), pix_last, tv[k].last);
      chk($sformatf("vec%0d done", k), done, tv[k].done);
      if (tv[k].valid) begin
        chk($sformatf("vec%0d data", k), pix_data, tv[k].data);
        chk($sformatf("vec%0d row", k), pix_row, tv[k].row);
        chk($sformatf("vec%0d col", k), pix_col, tv[k].col);
      end
    end
    start = 1'b0;

    // Same image, three stall cycles on pixel (0,1): done three cycles later.
    run_frame(100, 1, 0);

    rand_image();
    run_frame(100, -1, 0);

    for (int f = 0; f < 20; f++) begin
      rand_image();
      run_frame($urandom_range(30, 90), -1, 1);
    end

    // Reset during the select of the last row, then a clean frame.
    rand_image();
    start = 1'b1;
    step();
    start = 1'b0;
    pix_ready = 1'b1;
    n = 0;
    while (read !== (H'(1) << (H - 1)) && n < 50) begin
      step();
      n++;
    end
    chk("reached last row select", read, H'(1) << (H - 1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid reset read", read, 0);
    chk("mid reset valid", pix_valid, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset done", done, 0);
    seen = 0;
    repeat (20) begin
      step();
      if (done) seen = 1;
    end
    chk("no done after reset", seen, 0);
    rand_image();
    run_frame(100, -1, 0);

`ifdef READER_TEST_PATTERN_EN
    tm = 1'b1;
    test_mode = 1'b1;
    rand_image();
    run_frame(70, -1, 1);
    test_mode = 1'b0;
    tm = 1'b0;
    rand_image();
    run_frame(80, -1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
